riscv_div_unit: RTL and testbench
=================================

Name: riscv_div_unit

Overview:
- Iterative radix-2 divider executing the ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU operations of the alu_opcode_e set.
- Sits beside the single-cycle ALU in the execute stage. Decode issues an operation through a valid/ready handshake; the result is returned through a valid/ready handshake to writeback.
- Division by zero and signed overflow take a one-cycle fast path. All other divisions take 32 iteration cycles.

Parameters:
- XLEN, 32, operand and result width in bits.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush_i  in  1  pipeline kill; aborts any operation in progress.
- valid_i  in  1  request valid from decode.
- ready_o  out  1  unit can accept a request.
- op_i  in  7  alu_opcode_e value; must be one of the four DIV/REM codes when valid_i=1.
- a_i  in  XLEN  dividend (rs1).
- b_i  in  XLEN  divisor (rs2).
- valid_o  out  1  result valid.
- ready_i  in  1  writeback accepts the result.
- result_o  out  XLEN  quotient or remainder.

Behaviour:
- Op decode:
  - op_i[0]=1 selects signed; op_i[1]=1 selects remainder.
  - DIVU=0110000, DIV=0110001, REMU=0110010, REM=0110011.
  - op_i[6:2] other than 01100 while valid_i=1 is an illegal request. The bench asserts on it; the RTL behaviour is don't-care.
- Clock and reset: single clock, reset synchronous, active-low (rst_n), sampled on the clk rising edge.
- Reset state: state=IDLE, counter=0, all datapath registers=0, ready_o=1, valid_o=0, result_o=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - Accept occurs on valid_i & ready_o; this is cycle 0.
  - If b_i==0, or the op is signed with a_i=0x80000000 and b_i=0xFFFFFFFF: load the special result and go to DONE.
  - Otherwise latch |a|, |b| (absolute values only when signed), latch the sign flags and remainder select, set the partial remainder to 0 and counter=XLEN-1, and go to CALC.
- CALC:
  - ready_o=0, valid_o=0.
  - Each cycle performs one restoring step:
    - rem' = {rem, q[XLEN-1]}; q shifts left.
    - If rem' >= |b|, subtract |b| and shift in a 1; otherwise shift in a 0.
    - The subtraction is XLEN+1 bits wide.
  - At counter==0 the step completes, the sign fix-up registers result_o, and the FSM goes to DONE. Otherwise the counter decrements.
- Sign fix-up:
  - The quotient is negated when signed and sign(a) != sign(b).
  - The remainder is negated when signed and sign(a)=1.
- DONE:
  - valid_o=1, ready_o=0.
  - result_o is held stable until ready_i=1, then the FSM goes to IDLE.
  - A new request cannot be accepted in the same cycle as a DONE handshake; ready_o rises the next cycle.
- Latency:
  - Normal path: valid_o is high in cycle XLEN+1 (33).
  - Fast path: valid_o is high in cycle 1.
  - Throughput is one operation per 34 cycles, or per 2 cycles on the fast path, with ready_i held at 1.
- Special results:
  - Divide by zero: quotient = all ones (0xFFFFFFFF) for both signed and unsigned; remainder = a_i.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- Flush:
  - flush_i=1 in CALC or DONE returns the FSM to IDLE on the next edge.
  - valid_o is 0 the cycle after the flush and result_o is cleared.
  - flush_i in IDLE with valid_i=1 blocks the accept; flush has priority over valid_i.
- Reset mid-operation: synchronous reset in any state returns every output to its reset value on the next edge, with no partial result.
- Inputs a_i, b_i and op_i are only sampled at accept; changes afterwards have no effect.

Test Plan:
1. DIV a=100, b=7 with ready_i=1 -> valid_o high exactly in cycle 33, result_o=0x0000000E; ready_o high in cycle 34.
2. REM a=-100 (0xFFFFFF9C), b=7 -> result_o=0xFFFFFFFE (-2). DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF. REMU a=0xFFFFFFFF, b=0x10 -> 0x0000000F.
3. Fast paths, each with valid_o in cycle 1:
   - DIV 5/0 -> 0xFFFFFFFF.
   - REMU 5/0 -> 0x00000005.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
   - REM on the same operands -> 0x00000000.
4. Backpressure: DIVU 1000/10 with ready_i=0 for 5 cycles after valid_o rises -> result_o=0x00000064 stable and ready_o=0 throughout; handshake on the 6th cycle; IDLE next cycle.
5. Flush in cycle 10 of a CALC (DIV 1000/3) -> valid_o never rises, ready_o=1 in cycle 11. A following DIVU 9/3 -> result 3 in cycle 33 of its own accept.
6. rst_n=0 for one cycle during CALC, and separately during DONE -> next cycle ready_o=1, valid_o=0, result_o=0. The next request completes normally.

Source files
------------

// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in one cycle.
module riscv_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   result_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              rem_sel_q;

  logic              op_signed;
  logic              op_rem;
  logic              op_legal;
  logic              div_zero;
  logic              overflow;
  logic              fast_path;
  logic              accept;
  logic              last_step;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_step;
  logic [XLEN-1:0]   quo_step;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    logic signed [XLEN-1:0] s;
    s = signed'(v);
    return (is_signed && s < 0) ? unsigned'(-s) : v;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    logic signed [XLEN-1:0] s;
    s = signed'(v);
    return neg ? unsigned'(-s) : v;
  endfunction

  assign op_signed = op_i[0];
  assign op_rem    = op_i[1];
  assign op_legal  = (op_i[6:2] == 5'b01100);
  assign div_zero  = (b_i == '0);
  assign overflow  = op_signed && (a_i == INT_MIN) && (b_i == '1);
  assign fast_path = div_zero || overflow;
  assign accept    = (state_q == IDLE) && valid_i && !flush_i && op_legal;
  assign last_step = (cnt_q == '0);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op_rem ? a_i : '1;
    else          special_res = op_rem ? '0 : INT_MIN;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, div_q});
    rem_diff = rem_sh - {1'b0, div_q};
    rem_step = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], rem_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = fast_path ? DONE : CALC;
      end
      CALC: begin
        if (flush_i)        state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (flush_i || ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (flush_i && state_q != IDLE) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      if (fast_path) begin
        result_q <= special_res;
      end else begin
        quo_q     <= abs_val(a_i, op_signed);
        div_q     <= abs_val(b_i, op_signed);
        rem_q     <= '0;
        cnt_q     <= CNT_W'(XLEN-1);
        neg_quo_q <= op_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
        neg_rem_q <= op_signed && a_i[XLEN-1];
        rem_sel_q <= op_rem;
      end
    end else if (state_q == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      if (last_step)
        result_q <= rem_sel_q ? apply_sign(rem_step, neg_rem_q) : apply_sign(quo_step, neg_quo_q);
      else
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed testbench for riscv_div_unit: latency, signed/unsigned results,
// fast paths, backpressure, flush and mid-operation reset.
module tb_riscv_div_unit;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_DIVU = 7'b0110000;
  localparam logic [6:0] OP_DIV  = 7'b0110001;
  localparam logic [6:0] OP_REMU = 7'b0110010;
  localparam logic [6:0] OP_REM  = 7'b0110011;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [6:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;

  int tests_run;
  int tests_failed;

  riscv_div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && valid_i)
      assert (op_i[6:2] == 5'b01100) else $error("illegal opcode %b", op_i);
  end

  // Presents a request for one edge (cycle 0); returns #1 into cycle 1 with inputs scrambled.
  task automatic issue(input logic [6:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i    = OP_DIVU;
    a_i     = 32'hDEAD_BEEF;
    b_i     = 32'h0000_0000;
  endtask

  // Returns the cycle index (relative to accept) at which valid_o is seen high.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (valid_o !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    tests_run++;
    if (result_o !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 00000000", result_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_div_latency;
    int cyc;
    ready_i = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    wait_valid(cyc);
    tests_run++;
    if (cyc !== 33) begin tests_failed++; $display("FAIL div_latency: got cycle %0d expected 33", cyc); end
    tests_run++;
    if (result_o !== 32'h0000_000E) begin tests_failed++; $display("FAIL div_100_7: got %h expected 0000000e", result_o); end
    @(posedge clk); #1;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL div_cycle34: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
    end
  endtask

  task automatic test_signed_unsigned;
    logic [6:0]      ops [3] = '{OP_REM, OP_DIVU, OP_REMU};
    logic [XLEN-1:0] as  [3] = '{32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] bs  [3] = '{32'd7, 32'd2, 32'h10};
    logic [XLEN-1:0] exp [3] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0000_000F};
    int cyc;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(cyc);
      tests_run++;
      if (cyc !== 33 || result_o !== exp[i]) begin
        tests_failed++;
        $display("FAIL arith_%0d: got cycle %0d result %h expected cycle 33 result %h", i, cyc, result_o, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fast_path;
    logic [6:0]      ops [4] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [XLEN-1:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [XLEN-1:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    int cyc;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(cyc);
      tests_run++;
      if (cyc !== 1 || result_o !== exp[i]) begin
        tests_failed++;
        $display("FAIL fast_%0d: got cycle %0d result %h expected cycle 1 result %h", i, cyc, result_o, exp[i]);
      end
      tests_run++;
      if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL fast_ready_c1_%0d: got %b expected 0", i, ready_o); end
      @(posedge clk); #1;
      tests_run++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
        tests_failed++; $display("FAIL fast_c2_%0d: got ready=%b valid=%b expected ready=1 valid=0", i, ready_o, valid_o);
      end
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    ready_i = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_valid(cyc);
    tests_run++;
    if (cyc !== 33) begin tests_failed++; $display("FAIL bp_latency: got cycle %0d expected 33", cyc); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'h64) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b result=%h expected valid=1 ready=0 result=00000064", i, valid_o, ready_o, result_o);
      end
      if (i == 5) ready_i = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
    end
  endtask

  task automatic test_flush;
    int cyc;
    int highs;
    ready_i = 1'b1;
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL flush_c11: got ready=%b valid=%b result=%h expected ready=1 valid=0 result=00000000", ready_o, valid_o, result_o);
    end
    highs = 0;
    repeat (40) begin
      if (valid_o !== 1'b0) highs++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (highs !== 0) begin tests_failed++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", highs); end
    issue(OP_DIVU, 32'd9, 32'd3);
    wait_valid(cyc);
    tests_run++;
    if (cyc !== 33 || result_o !== 32'd3) begin
      tests_failed++; $display("FAIL flush_next: got cycle %0d result %h expected cycle 33 result 00000003", cyc, result_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    ready_i = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_calc: got ready=%b valid=%b result=%h expected ready=1 valid=0 result=00000000", ready_o, valid_o, result_o);
    end
    ready_i = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_valid(cyc);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_done: got ready=%b valid=%b result=%h expected ready=1 valid=0 result=00000000", ready_o, valid_o, result_o);
    end
    ready_i = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    wait_valid(cyc);
    tests_run++;
    if (cyc !== 33 || result_o !== 32'h0000_000E) begin
      tests_failed++; $display("FAIL rst_next: got cycle %0d result %h expected cycle 33 result 0000000e", cyc, result_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    valid_i      = 1'b0;
    ready_i      = 1'b1;
    op_i         = OP_DIVU;
    a_i          = '0;
    b_i          = '0;
    test_reset();
    test_div_latency();
    test_signed_unsigned();
    test_fast_path();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
